collatz_responder: RTL and testbench
====================================

COLLATZ_RESPONDER -- requirements
Module: collatz_responder

Interface
REQ-001 SHALL have parameter STEP_BITS, default 16, width of the step counter.
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on posedge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port go, input, 1, start request, sampled on posedge, level or pulse.
REQ-005 SHALL have port n, input, 32, start value, captured on the edge go is sampled high.
REQ-006 SHALL have port dout, output, 32, current sequence value (registered).
REQ-007 SHALL have port done, output, 1, high while in DONE.
REQ-008 SHALL have port busy, output, 1, high while in RUN.
REQ-009 SHALL have port steps, output, STEP_BITS, number of iterations applied since capture.
REQ-010 SHALL have port peak, output, 32, largest dout value since capture.
REQ-011 SHALL have port err, output, 1, high while in ERR.
REQ-012 SHALL have port ovf, output, 1, in ERR, 1 = arithmetic overflow cause, 0 = zero start or step-limit cause.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE, ERR; done/busy/err decoded combinationally from state only.
REQ-014 SHALL, in any state with go=1 and reset=0, on the edge: dout<=n, peak<=n, steps<=0, ovf<=0, next state RUN if n!=0, else ERR.
REQ-015 SHALL give go priority over any in-progress iteration (restart while RUN discards current run, no done pulse).
REQ-016 SHALL, in RUN with go=0 and dout==1, move to DONE; dout, steps, peak unchanged.
REQ-017 SHALL, in RUN with go=0 and dout even, load dout<=dout>>1 and steps<=steps+1.
REQ-018 SHALL, in RUN with go=0 and dout odd, !=1, compute 3*dout+1 at 34 bits; if result > 32'hFFFFFFFF, move to ERR with ovf<=1, dout/steps unchanged; else dout<=result[31:0], steps<=steps+1.
REQ-019 SHALL update peak<=new dout whenever the new dout exceeds peak.
REQ-020 SHALL, in RUN, when steps equals all-ones and dout!=1, move to ERR with ovf<=0 instead of iterating; steps never wraps.
REQ-021 SHALL hold DONE and ERR (all outputs frozen) until go or reset.
REQ-022 SHALL hold outputs in IDLE until go.
REQ-023 SHALL have latency: n=1 -> done high two edges after the go edge; in general, done is first seen high steps+2 edges after the go edge (go edge counted as edge 1).
REQ-024 SHALL present done for the requesting initiator as level, not pulse; initiator counts cycles from its own go until done.

Reset
REQ-025 SHALL, on reset=1 at a posedge, enter IDLE and clear dout, steps, peak, ovf to 0, irrespective of go or state, including mid-RUN.
REQ-026 SHALL have reset take priority over go on the same edge.
REQ-027 SHALL produce, after reset, done=0, busy=0, err=0 until a go is sampled.

Verification
REQ-028 SHALL cover: reset, go with n=1 -> busy one cycle, then done=1, steps=0, peak=1, dout=1.
REQ-029 SHALL cover: go with n=6 -> done with steps=8, peak=16, dout=1; done first high on the 10th edge after go.
REQ-030 SHALL cover: go with n=27 -> done with steps=111, peak=9232.
REQ-031 SHALL cover: go with n=0 -> err=1, ovf=0, steps=0 on the next cycle; go with n=0xAAAAAAAB -> err=1, ovf=1, dout=0xAAAAAAAB, steps=0.
REQ-032 SHALL cover: go n=27, re-go with n=6 after 20 cycles -> run restarts, final steps=8, peak=16; reset asserted mid-run -> IDLE, all outputs 0, no done.
REQ-033 SHALL cover: STEP_BITS=4, go n=27 -> err=1, ovf=0, steps=15.

Source files
------------

// File: rtl/collatz_responder.sv
// rtl/collatz_responder.sv - Collatz sequence iterator with step count, peak tracking and error reporting.
module collatz_responder #(
    parameter int STEP_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [31:0]          n,
    output logic [31:0]          dout,
    output logic                 done,
    output logic                 busy,
    output logic [STEP_BITS-1:0] steps,
    output logic [31:0]          peak,
    output logic                 err,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ERR
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [31:0]          dout_nxt;
    logic [31:0]          peak_nxt;
    logic [STEP_BITS-1:0] steps_nxt;
    logic                 ovf_nxt;

    logic [33:0]          triple;
    logic                 steps_max;

    // 3*dout+1 held at 34 bits so any carry past bit 31 flags overflow.
    assign triple    = {2'b00, dout} + {1'b0, dout, 1'b0} + 34'd1;
    assign steps_max = &steps;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dout  <= '0;
            peak  <= '0;
            steps <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            dout  <= dout_nxt;
            peak  <= peak_nxt;
            steps <= steps_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dout_nxt  = dout;
        peak_nxt  = peak;
        steps_nxt = steps;
        ovf_nxt   = ovf;

        if (go) begin
            // A new request always wins, even over a run in progress.
            dout_nxt  = n;
            peak_nxt  = n;
            steps_nxt = '0;
            ovf_nxt   = 1'b0;
            state_nxt = (n != 32'd0) ? RUN : ERR;
        end else begin
            case (state)
                RUN: begin
                    if (dout == 32'd1) begin
                        state_nxt = DONE;
                    end else if (steps_max) begin
                        state_nxt = ERR;
                        ovf_nxt   = 1'b0;
                    end else if (!dout[0]) begin
                        dout_nxt  = dout >> 1;
                        steps_nxt = steps + 1'b1;
                    end else if (triple[33:32] != 2'b00) begin
                        state_nxt = ERR;
                        ovf_nxt   = 1'b1;
                    end else begin
                        dout_nxt  = triple[31:0];
                        steps_nxt = steps + 1'b1;
                        if (triple[31:0] > peak) begin
                            peak_nxt = triple[31:0];
                        end
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    assign done = (state == DONE);
    assign busy = (state == RUN);
    assign err  = (state == ERR);

endmodule

// File: tb/tb_collatz_responder.sv
// tb/tb_collatz_responder.sv - Table-driven and randomized checks of collatz_responder against a reference model.
module tb_collatz_responder;

    logic        clk;
    logic        reset;
    logic        go;
    logic [31:0] n;

    logic [31:0] dout;
    logic        done;
    logic        busy;
    logic [15:0] steps;
    logic [31:0] peak;
    logic        err;
    logic        ovf;

    logic [31:0] dout_b;
    logic        done_b;
    logic        busy_b;
    logic [3:0]  steps_b;
    logic [31:0] peak_b;
    logic        err_b;
    logic        ovf_b;

    int pass_cnt;
    int total_cnt;

    collatz_responder #(.STEP_BITS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .n     (n),
        .dout  (dout),
        .done  (done),
        .busy  (busy),
        .steps (steps),
        .peak  (peak),
        .err   (err),
        .ovf   (ovf)
    );

    collatz_responder #(.STEP_BITS(4)) dut_small (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .n     (n),
        .dout  (dout_b),
        .done  (done_b),
        .busy  (busy_b),
        .steps (steps_b),
        .peak  (peak_b),
        .err   (err_b),
        .ovf   (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] n;
        bit          exp_err;
        bit          exp_ovf;
        int          exp_steps;
        logic [31:0] exp_peak;
        logic [31:0] exp_dout;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Straight arithmetic walk of the sequence; latency follows from the step count.
    task automatic model(input logic [31:0] start, input int limit, output vec_t r);
        longint x;
        longint y;
        r.n         = start;
        r.exp_err   = 0;
        r.exp_ovf   = 0;
        r.exp_steps = 0;
        r.exp_peak  = start;
        r.exp_dout  = start;
        if (start == 0) begin
            r.exp_err = 1;
            r.exp_lat = 1;
            return;
        end
        x = longint'(start);
        forever begin
            if (x == 1) break;
            if (r.exp_steps == limit) begin
                r.exp_err = 1;
                break;
            end
            if (x % 2 == 0) begin
                x = x / 2;
            end else begin
                y = 3 * x + 1;
                if (y > 64'hFFFF_FFFF) begin
                    r.exp_err = 1;
                    r.exp_ovf = 1;
                    break;
                end
                x = y;
            end
            r.exp_steps++;
            if (x > longint'(r.exp_peak)) r.exp_peak = x[31:0];
        end
        r.exp_dout = x[31:0];
        r.exp_lat  = r.exp_steps + 2;
    endtask

    // Issue go for one edge, then count edges until done or err (go edge is edge 1).
    task automatic run_go(input logic [31:0] v, input int budget, output int lat, output bit busy_first);
        @(negedge clk);
        n  = v;
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        lat = 1;
        busy_first = busy;
        while (!(done || err) && lat < budget) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic apply_and_check(input string tag, input vec_t v);
        int lat;
        bit bf;
        run_go(v.n, 70000, lat, bf);
        check({tag, " done"},  64'(done),  64'(!v.exp_err));
        check({tag, " err"},   64'(err),   64'(v.exp_err));
        check({tag, " ovf"},   64'(ovf),   64'(v.exp_ovf));
        check({tag, " steps"}, 64'(steps), 64'(v.exp_steps));
        check({tag, " peak"},  64'(peak),  64'(v.exp_peak));
        check({tag, " dout"},  64'(dout),  64'(v.exp_dout));
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    endtask

    vec_t vecs[9];
    vec_t mv;
    int   lat;
    bit   bf;
    logic [31:0] r;
    logic [31:0] held;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset = 1'b1;
        go    = 1'b0;
        n     = '0;

        vecs[0] = '{32'd1,          0, 0, 0,   32'd1,          32'd1,          2};
        vecs[1] = '{32'd6,          0, 0, 8,   32'd16,         32'd1,          10};
        vecs[2] = '{32'd27,         0, 0, 111, 32'd9232,       32'd1,          113};
        vecs[3] = '{32'd0,          1, 0, 0,   32'd0,          32'd0,          1};
        vecs[4] = '{32'hAAAAAAAB,   1, 1, 0,   32'hAAAAAAAB,   32'hAAAAAAAB,   2};
        vecs[5] = '{32'd2,          0, 0, 1,   32'd2,          32'd1,          3};
        vecs[6] = '{32'h80000000,   0, 0, 31,  32'h80000000,   32'd1,          33};
        vecs[7] = '{32'h55555555,   1, 1, 0,   32'h55555555,   32'h55555555,   2};
        vecs[8] = '{32'd7,          0, 0, 16,  32'd52,         32'd1,          18};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset done",  64'(done),  64'd0);
        check("reset busy",  64'(busy),  64'd0);
        check("reset err",   64'(err),   64'd0);
        check("reset dout",  64'(dout),  64'd0);
        check("reset steps", 64'(steps), 64'd0);
        check("reset peak",  64'(peak),  64'd0);
        check("reset ovf",   64'(ovf),   64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle hold done", 64'(done | busy | err), 64'd0);

        run_go(32'd1, 100, lat, bf);
        check("n1 busy first cycle", 64'(bf), 64'd1);

        for (int i = 0; i < 9; i++) begin
            apply_and_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Small-counter instance saw the n=27 go above and stops at the step limit.
        apply_and_check("n27 again", vecs[2]);
        check("small err",   64'(err_b),   64'd1);
        check("small ovf",   64'(ovf_b),   64'd0);
        check("small steps", 64'(steps_b), 64'd15);
        check("small done",  64'(done_b),  64'd0);

        held = dout;
        repeat (5) @(negedge clk);
        check("done frozen", 64'(done), 64'd1);
        check("dout frozen", 64'(dout), 64'(held));

        // Restart mid-run: no done pulse from the abandoned run.
        @(negedge clk);
        n  = 32'd27;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        bf = 0;
        repeat (19) begin
            @(negedge clk);
            if (done) bf = 1;
        end
        check("no done before restart", 64'(bf), 64'd0);
        run_go(32'd6, 1000, lat, bf);
        check("restart steps",   64'(steps), 64'd8);
        check("restart peak",    64'(peak),  64'd16);
        check("restart done",    64'(done),  64'd1);
        check("restart latency", 64'(lat),   64'd10);

        // Reset mid-run.
        @(negedge clk);
        n  = 32'd27;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst state", 64'({done, busy, err}), 64'd0);
        check("midrst dout",  64'(dout),  64'd0);
        check("midrst steps", 64'(steps), 64'd0);
        check("midrst peak",  64'(peak),  64'd0);
        check("midrst ovf",   64'(ovf),   64'd0);

        // Reset and go on the same edge: reset wins.
        n     = 32'd6;
        go    = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        go    = 1'b0;
        reset = 1'b0;
        bf = 0;
        repeat (12) begin
            @(negedge clk);
            if (done | busy | err) bf = 1;
        end
        check("reset over go", 64'(bf), 64'd0);
        check("reset over go dout", 64'(dout), 64'd0);

        for (int i = 0; i < 30; i++) begin
            case (i % 3)
                0: r = $urandom_range(1, 100000);
                1: r = $urandom;
                default: r = ($urandom_range(0, 1) != 0) ? 32'h55555553 - 32'($urandom_range(0, 16)) : 32'($urandom_range(0, 3));
            endcase
            model(r, 65535, mv);
            apply_and_check($sformatf("rand%0d n=0x%0h", i, r), mv);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
